fifo_queue: RTL and testbench

// - Single-clock synchronous FIFO. It buffers WIDTH-bit words between a producer and a

---
 rtl/fifo_queue_pkg.sv | 8 +
 rtl/fifo_queue_ram.sv | 41 ++++
 rtl/fifo_queue.sv | 85 ++++++++
 tb/tb_fifo_queue.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_queue_pkg.sv
// Shared defaults for the fifo_queue block and its storage sub-module.
package fifo_queue_pkg;

  // Default geometry: four entries of one 32-bit audio sample each.
  localparam int FIFO_DEFAULT_DEPTH = 4;
  localparam int FIFO_DEFAULT_WIDTH = 32;

endpackage : fifo_queue_pkg

// File: rtl/fifo_queue_ram.sv
// Simple dual-port storage for fifo_queue: one write port, one registered
// read port. Contents are never reset; only the read register is.
module fifo_queue_ram
  import fifo_queue_pkg::*;
#(
  parameter int DEPTH = FIFO_DEFAULT_DEPTH,
  parameter int WIDTH = FIFO_DEFAULT_WIDTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Write port: storage has no reset so it maps onto block/distributed RAM.
  always_ff @(posedge i_clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read port: holds its value until the next accepted read.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule : fifo_queue_ram

// File: rtl/fifo_queue.sv
// Single-clock synchronous FIFO. The occupancy count is the only source of
// full/empty truth, so the pointers can simply wrap without an extra bit.
module fifo_queue
  import fifo_queue_pkg::*;
#(
  parameter int DEPTH = FIFO_DEFAULT_DEPTH,
  parameter int WIDTH = FIFO_DEFAULT_WIDTH
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_write,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_read,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_empty,
  output logic                     o_almost_full,
  output logic [$clog2(DEPTH):0]   o_queued
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_COUNT   = CW'(DEPTH);
  localparam logic [CW-1:0] ALMOST_COUNT = CW'(DEPTH - 1);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic w_wr_en;
  logic w_rd_en;

  // A write is dropped when full (even with a read this edge); a read is
  // ignored when empty (even with a write this edge).
  always_comb begin
    w_wr_en = i_write && (r_count != FULL_COUNT);
    w_rd_en = i_read  && (r_count != '0);
  end

  // Pointer and occupancy bookkeeping; simultaneous push+pop leaves count alone.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_en) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_rd_en) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (w_wr_en && !w_rd_en) begin
        r_count <= r_count + CW'(1);
      end else if (w_rd_en && !w_wr_en) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // When reading and writing together with count>=1 the two addresses
  // differ, so the read returns the old head with no bypass path.
  fifo_queue_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_we    (w_wr_en),
    .i_waddr (r_wptr),
    .i_wdata (i_wdata),
    .i_re    (w_rd_en),
    .i_raddr (r_rptr),
    .o_rdata (o_rdata)
  );

  // Status flags decode straight from the registered count.
  always_comb begin
    o_empty       = (r_count == '0);
    o_almost_full = (r_count >= ALMOST_COUNT);
    o_queued      = r_count;
  end

endmodule : fifo_queue

// File: tb/tb_fifo_queue.sv
// Self-checking bench for fifo_queue (DEPTH=4, WIDTH=32) against a
// queue-based reference model.
module tb_fifo_queue;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr;
  logic             rd;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             empty;
  logic             afull;
  logic [2:0]       queued;

  logic [WIDTH-1:0] mq [$];
  logic [WIDTH-1:0] m_rdata;
  int checks;
  int errors;
  int txn;

  always #5 clk = ~clk;

  fifo_queue #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_write       (wr),
    .i_wdata       (wdata),
    .i_read        (rd),
    .o_rdata       (rdata),
    .o_empty       (empty),
    .o_almost_full (afull),
    .o_queued      (queued)
  );

  // One clock transaction: drive on the falling edge, update the model at
  // the rising edge, leave outputs settled 1 time unit after it.
  task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r);
    bit acc_r;
    bit acc_w;
    int sz;
    @(negedge clk);
    wr = w; wdata = d; rd = r;
    @(posedge clk);
    sz    = mq.size();
    acc_r = r && (sz > 0);
    acc_w = w && (sz < DEPTH);
    if (acc_r) m_rdata = mq.pop_front();
    if (acc_w) mq.push_back(d);
    #1;
    wr = 1'b0; rd = 1'b0;
    txn++;
    $display("txn %0d wr=%0b rd=%0b wdata=%08h rdata=%08h queued=%0d empty=%0b afull=%0b",
             txn, w, r, d, rdata, queued, empty, afull);
  endtask

  task automatic model_reset();
    mq.delete();
    m_rdata = '0;
  endtask

  task automatic test_reset();
    // Power-on reset
    rst = 1'b1; wr = 1'b0; rd = 1'b0; wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    checks++;
    if (empty !== 1'b1 || queued !== 3'd0 || rdata !== 32'h0 || afull !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial got empty=%0b queued=%0d rdata=%08h afull=%0b want 1 0 0 0",
               empty, queued, rdata, afull);
    end
    // Mid-fill asynchronous reset: three words queued, one already read out.
    step(1'b1, 32'hA0A0A0A0, 1'b0);
    step(1'b1, 32'hB1B1B1B1, 1'b0);
    step(1'b1, 32'hC2C2C2C2, 1'b0);
    step(1'b1, 32'hD3D3D3D3, 1'b1);
    checks++;
    if (queued !== 3'd3 || rdata !== 32'hA0A0A0A0) begin
      errors++;
      $display("FAIL reset_prefill got queued=%0d rdata=%08h want 3 a0a0a0a0", queued, rdata);
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (empty !== 1'b1 || queued !== 3'd0 || rdata !== 32'h0 || afull !== 1'b0) begin
      errors++;
      $display("FAIL reset_async got empty=%0b queued=%0d rdata=%08h afull=%0b want 1 0 0 0",
               empty, queued, rdata, afull);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'h11111111 * (i + 1), 1'b0);
      checks++;
      if (queued !== 3'(i + 1) || afull !== (i + 1 >= 3) || empty !== 1'b0) begin
        errors++;
        $display("FAIL fill_%0d got queued=%0d afull=%0b empty=%0b want %0d %0b 0",
                 i, queued, afull, empty, i + 1, (i + 1 >= 3));
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b1);
      checks++;
      if (rdata !== 32'h11111111 * (i + 1) || queued !== 3'(3 - i)) begin
        errors++;
        $display("FAIL drain_%0d got rdata=%08h queued=%0d want %08h %0d",
                 i, rdata, queued, 32'h11111111 * (i + 1), 3 - i);
      end
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL drain_empty got %0b want 1", empty);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) step(1'b1, 32'h01000000 + i, 1'b0);
    step(1'b1, 32'hDEADBEEF, 1'b0);
    checks++;
    if (queued !== 3'd4 || afull !== 1'b1) begin
      errors++;
      $display("FAIL overflow_count got queued=%0d afull=%0b want 4 1", queued, afull);
    end
    // Full with read+write: write dropped, read accepted.
    step(1'b1, 32'hDEADBEEF, 1'b1);
    checks++;
    if (queued !== 3'd3 || rdata !== 32'h01000000) begin
      errors++;
      $display("FAIL overflow_rw got queued=%0d rdata=%08h want 3 01000000", queued, rdata);
    end
    for (int i = 1; i < 4; i++) begin
      step(1'b0, '0, 1'b1);
      checks++;
      if (rdata !== 32'h01000000 + i) begin
        errors++;
        $display("FAIL overflow_drain_%0d got %08h want %08h", i, rdata, 32'h01000000 + i);
      end
    end
    checks++;
    if (empty !== 1'b1 || queued !== 3'd0) begin
      errors++;
      $display("FAIL overflow_end got empty=%0b queued=%0d want 1 0", empty, queued);
    end
  endtask

  task automatic test_underflow();
    logic [WIDTH-1:0] last;
    last = m_rdata;
    step(1'b0, '0, 1'b1);
    checks++;
    if (rdata !== last || queued !== 3'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL underflow_read got rdata=%08h queued=%0d want %08h 0", rdata, queued, last);
    end
    step(1'b1, 32'h5A5A5A5A, 1'b1);
    checks++;
    if (rdata !== last || queued !== 3'd1) begin
      errors++;
      $display("FAIL underflow_rw got rdata=%08h queued=%0d want %08h 1", rdata, queued, last);
    end
    step(1'b0, '0, 1'b1);
    checks++;
    if (rdata !== 32'h5A5A5A5A || queued !== 3'd0) begin
      errors++;
      $display("FAIL underflow_after got rdata=%08h queued=%0d want 5a5a5a5a 0", rdata, queued);
    end
  endtask

  task automatic test_simultaneous();
    step(1'b1, 32'hAAAA0001, 1'b0);
    step(1'b1, 32'hBBBB0002, 1'b0);
    step(1'b1, 32'hCCCC0003, 1'b1);
    checks++;
    if (rdata !== 32'hAAAA0001 || queued !== 3'd2) begin
      errors++;
      $display("FAIL simul_rw got rdata=%08h queued=%0d want aaaa0001 2", rdata, queued);
    end
    step(1'b0, '0, 1'b1);
    checks++;
    if (rdata !== 32'hBBBB0002) begin
      errors++;
      $display("FAIL simul_b got %08h want bbbb0002", rdata);
    end
    step(1'b0, '0, 1'b1);
    checks++;
    if (rdata !== 32'hCCCC0003 || empty !== 1'b1) begin
      errors++;
      $display("FAIL simul_c got rdata=%08h empty=%0b want cccc0003 1", rdata, empty);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, $urandom, 1'b1);
      checks++;
      if (rdata !== m_rdata || queued !== 3'd3 || queued > 3'd4) begin
        errors++;
        $display("FAIL wrap_%0d got rdata=%08h queued=%0d want %08h 3", i, rdata, queued, m_rdata);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b1);
      checks++;
      if (rdata !== m_rdata) begin
        errors++;
        $display("FAIL wrap_drain_%0d got %08h want %08h", i, rdata, m_rdata);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      checks++;
      if (rdata !== m_rdata || queued !== 3'(mq.size()) ||
          empty !== (mq.size() == 0) || afull !== (mq.size() >= DEPTH - 1)) begin
        errors++;
        $display("FAIL random_%0d got rdata=%08h queued=%0d empty=%0b afull=%0b want %08h %0d %0b %0b",
                 i, rdata, queued, empty, afull, m_rdata, mq.size(),
                 (mq.size() == 0), (mq.size() >= DEPTH - 1));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    txn    = 0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_simultaneous();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fifo_queue
